// File: rtl/halt_ctrl_pkg.sv
// Shared types and defaults for the timer halt controller.
// The timer width is common to the drain timeout and the resume delay.
package halt_ctrl_pkg;

  localparam int unsigned STATE_W           = 2;
  localparam int unsigned TMR_W             = 8;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 16;
  localparam int unsigned DEF_RESUME_DLY    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_RESUME = 2'd3
  } state_e;

endpackage

// File: rtl/halt_ctrl_tmr.sv
// Loadable 8-bit down-counter with zero flag; load wins over decrement.
// It saturates at zero rather than wrapping.
module halt_ctrl_tmr
  import halt_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/halt_ctrl.sv
// Debug halt sequencer for the timer counter: drains to a safe stop point
// (or forces a halt on timeout), holds, then resumes after a fixed delay.
module halt_ctrl
  import halt_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int unsigned RESUME_DLY    = DEF_RESUME_DLY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_req,
  input  logic               dbg_en,
  input  logic               cnt_idle,
  input  logic               forced_clr,
  output logic               dbg_mode,
  output logic               cnt_en,
  output logic               halt_forced,
  output logic [STATE_W-1:0] state
);

  localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RESUME_LOAD = TMR_W'(RESUME_DLY - 1);

  state_e           state_q, state_d;
  logic             cnt_en_q, dbg_mode_q, forced_q;
  logic             go;
  logic             forced_set;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_load_val;

  assign go = halt_req & dbg_en;

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    forced_set   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (go) begin
          state_d      = ST_DRAIN;
          tmr_load     = 1'b1;
          tmr_load_val = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // Abort beats both the clean and the forced halt entry.
        if (!go) begin
          state_d = ST_RUN;
        end else if (cnt_idle) begin
          state_d = ST_HALTED;
        end else if (tmr_zero) begin
          state_d    = ST_HALTED;
          forced_set = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HALTED: begin
        if (!go) begin
          state_d      = ST_RESUME;
          tmr_load     = 1'b1;
          tmr_load_val = RESUME_LOAD;
        end
      end
      ST_RESUME: begin
        if (go) begin
          state_d = ST_HALTED;
        end else if (tmr_zero) begin
          state_d = ST_RUN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_en_q   <= 1'b1;
      dbg_mode_q <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_en_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      dbg_mode_q <= (state_d == ST_HALTED);
      if (forced_set) begin
        forced_q <= 1'b1;
      end else if (forced_clr) begin
        forced_q <= 1'b0;
      end
    end
  end

  halt_ctrl_tmr u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign state       = state_q;
  assign cnt_en      = cnt_en_q;
  assign dbg_mode    = dbg_mode_q;
  assign halt_forced = forced_q;

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 16: maximum cycles spent in DRAIN before a forced halt; legal range 2..255.
REQ-002 Parameter RESUME_DLY, default 2: cycles spent in RESUME before the counter restarts; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 halt_req  input  1  halt request bit from the timer halt CSR.
REQ-006 dbg_en  input  1  external debug enable; halt is honoured only while high.
REQ-007 cnt_idle  input  1  timer counter is at a safe stop point this cycle.
REQ-008 forced_clr  input  1  single-cycle pulse; clears halt_forced.
REQ-009 dbg_mode  output  1  timer is halted; feeds the CSR halt_ack term.
REQ-010 cnt_en  output  1  counter increment enable.
REQ-011 halt_forced  output  1  sticky flag: the last halt entry was forced by drain timeout.
REQ-012 state  output  2  current FSM state, for status/debug.

Function
REQ-013 FSM states: RUN=0, DRAIN=1, HALTED=2, RESUME=3; Moore outputs decoded from the state register only.
REQ-014 cnt_en = 1 in RUN and DRAIN, 0 in HALTED and RESUME; dbg_mode = 1 only in HALTED.
REQ-015 RUN -> DRAIN when halt_req & dbg_en is sampled high; otherwise stay in RUN.
REQ-016 On DRAIN entry, load the timer with DRAIN_TIMEOUT-1; decrement it once per DRAIN cycle.
REQ-017 DRAIN -> HALTED when cnt_idle=1; halt_forced is left unchanged.
REQ-018 DRAIN -> HALTED with halt_forced set when cnt_idle=0 and the timer equals 0, i.e. after exactly DRAIN_TIMEOUT DRAIN cycles.
REQ-019 If cnt_idle=1 and the timer equals 0 in the same cycle, treat it as a normal entry: halt_forced is not set.
REQ-020 DRAIN -> RUN when halt_req=0 or dbg_en=0; this has priority over REQ-017/018.
REQ-021 HALTED -> RESUME when halt_req=0 or dbg_en=0; the timer loads RESUME_DLY-1.
REQ-022 RESUME decrements the timer and goes to RUN when the timer equals 0, so RESUME lasts exactly RESUME_DLY cycles.
REQ-023 RESUME -> HALTED when halt_req & dbg_en is high again; this has priority over REQ-022 and the counter stays stopped.
REQ-024 Latency: halt_req rises before edge N with cnt_idle=1 -> DRAIN after edge N, dbg_mode=1 / cnt_en=0 after edge N+1.
REQ-025 halt_forced clears on forced_clr; if a forced set occurs in the same cycle, the set wins.
REQ-026 Timer width is 8 bits; it never wraps below 0 (it holds at 0).

Reset
REQ-027 While rst_n=0 at a clock edge: state=RUN, timer=0, halt_forced=0, hence cnt_en=1, dbg_mode=0.
REQ-028 Reset asserted in any state, including mid-DRAIN or mid-RESUME, takes effect at the next edge with no residual timer or flag state.
REQ-029 There is no asynchronous path; outputs change only on clock edges.

Structure
REQ-030 Shared package holds the state enum (RUN/DRAIN/HALTED/RESUME), the 2-bit state width constant and the default DRAIN_TIMEOUT/RESUME_DLY values.
REQ-031 One sub-module, halt_ctrl_tmr: an 8-bit loadable down-counter with a zero flag, shared between the drain timeout and the resume delay.
REQ-032 The block has no combinational path from any input to any output.

Verification
REQ-033 Reset, then halt_req=1, dbg_en=1, cnt_idle=1 -> state 0->1->2; dbg_mode=1 two edges after the request; halt_forced=0.
REQ-034 halt_req=1, dbg_en=1, cnt_idle=0 held -> 16 DRAIN cycles, then HALTED with halt_forced=1; a forced_clr pulse -> halt_forced=0.
REQ-035 In HALTED, drop halt_req -> RESUME for exactly 2 cycles with cnt_en=0, then RUN with cnt_en=1.
REQ-036 dbg_en=0 with halt_req=1 -> stays in RUN with cnt_en=1; dbg_en falls during HALTED -> RESUME.
REQ-037 halt_req reasserted on the 1st RESUME cycle -> back to HALTED with no cnt_en pulse; halt_req dropped in DRAIN cycle 5 -> RUN.
REQ-038 rst_n=0 in DRAIN cycle 8 -> RUN next edge; a subsequent halt sees a fresh 16-cycle timeout.
